// File: rtl/spi_slave_ctrl_if.sv
// SPI slave front-end bundle: serial pins plus the parallel word/byte
// handshake toward the memory stage.
interface spi_slave_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave serial front end: frames each SS_n-low transaction, deserialises
// a {cmd[1:0], payload} word MSB first, and for read-data frames shifts one
// returned byte out on MISO. clk is the SPI serial clock.
module spi_slave_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  bus
);

  localparam int WORD_W = DATA_W + 2;
  localparam int CNT_W  = $clog2(WORD_W + 2);
  localparam int TXC_W  = $clog2(DATA_W + 1);

  // bit_cnt_q counts word bits taken; two extra values mark the read-back phase
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_W - 1); // final bit on this edge
  localparam logic [CNT_W-1:0] CNT_DONE  = CNT_W'(WORD_W);     // word complete
  localparam logic [CNT_W-1:0] CNT_ARMED = CNT_W'(WORD_W + 1); // tx_valid now honoured

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [WORD_W-2:0]   rx_shift_q;
  logic [WORD_W-1:0]   rx_data_q;
  logic                rx_valid_q;
  logic                rd_addr_seen_q;
  logic                miso_q;
  logic [DATA_W-1:0]   tx_shift_q;
  logic [TXC_W-1:0]    tx_cnt_q;
  logic                tx_used_q;

  logic                data_state;
  logic                frame_abort;
  logic                take_bit;
  logic                word_done;
  logic                tx_wait;
  logic                tx_phase;
  logic [WORD_W-1:0]   word_full;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: SS_n high anywhere in a frame returns to IDLE
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (!bus.SS_n) state_d = CHK_CMD;
    end else if (bus.SS_n) begin
      state_d = IDLE;
    end else if (state_q == CHK_CMD) begin
      if (!bus.MOSI)          state_d = WRITE;
      else if (rd_addr_seen_q) state_d = READ_DATA;
      else                     state_d = READ_ADD;
    end
  end

  // Output/control decode for the datapath
  always_comb begin
    data_state  = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    frame_abort = (state_q != IDLE) && bus.SS_n;
    take_bit    = !bus.SS_n && ((state_q == CHK_CMD) || (data_state && (bit_cnt_q < CNT_DONE)));
    word_done   = !bus.SS_n && data_state && (bit_cnt_q == CNT_LAST);
    tx_wait     = !bus.SS_n && (state_q == READ_DATA) && (bit_cnt_q == CNT_DONE);
    tx_phase    = !bus.SS_n && (state_q == READ_DATA) && (bit_cnt_q == CNT_ARMED);
    word_full   = {rx_shift_q, bus.MOSI};
  end

  // Datapath: receive shift, word publish, read-address tracking, MISO shift-out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      miso_q         <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
      tx_used_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q == IDLE || frame_abort) begin
        // Partial words are dropped; rd_addr_seen survives an abort
        bit_cnt_q  <= '0;
        rx_shift_q <= '0;
        miso_q     <= 1'b0;
        tx_shift_q <= '0;
        tx_cnt_q   <= '0;
        tx_used_q  <= 1'b0;
      end else begin
        if (take_bit) begin
          rx_shift_q <= word_full[WORD_W-2:0];
          bit_cnt_q  <= bit_cnt_q + 1'b1;
        end
        if (word_done) begin
          rx_data_q  <= word_full;
          rx_valid_q <= 1'b1;
          if (word_full[WORD_W-1 -: 2] == 2'b10) rd_addr_seen_q <= 1'b1;
          else if (word_full[WORD_W-1 -: 2] == 2'b11) rd_addr_seen_q <= 1'b0;
        end
        // The edge right after the word ignores tx_valid, which may be stale
        if (tx_wait) bit_cnt_q <= CNT_ARMED;
        if (tx_phase) begin
          if (!tx_used_q) begin
            if (bus.tx_valid) begin
              tx_used_q  <= 1'b1;
              miso_q     <= bus.tx_data[DATA_W-1];
              tx_shift_q <= bus.tx_data << 1;
              tx_cnt_q   <= TXC_W'(DATA_W - 1);
            end
          end else if (tx_cnt_q != '0) begin
            miso_q     <= tx_shift_q[DATA_W-1];
            tx_shift_q <= tx_shift_q << 1;
            tx_cnt_q   <= tx_cnt_q - 1'b1;
          end else begin
            miso_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: expected words and MISO bits go into
// queues as stimulus is driven and are popped when the DUT should produce them.
module tb_spi_slave_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [9:0] exp_q[$];
  logic       miso_exp_q[$];

  spi_slave_ctrl_if #(.DATA_W(8)) bus ();

  spi_slave_ctrl #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // E0..E10 of one frame; SS_n left low afterwards
  task automatic send_word(input logic [9:0] w);
    logic [9:0] e;
    exp_q.push_back(w);
    bus.SS_n = 1'b0;
    tick();
    check("e0_rx_valid", 16'(bus.rx_valid), 16'd0);
    for (int i = 9; i >= 0; i--) begin
      bus.MOSI = w[i];
      tick();
      check("rx_miso_zero", 16'(bus.MISO), 16'd0);
      if (i == 0) begin
        check("rx_valid_e10", 16'(bus.rx_valid), 16'd1);
        e = exp_q.pop_front();
        check("rx_data", 16'(bus.rx_data), 16'(e));
      end else begin
        check("rx_valid_low", 16'(bus.rx_valid), 16'd0);
      end
    end
  endtask

  // SS_n high for one edge: back to IDLE, any pulse already cleared
  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
    check("end_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("end_miso", 16'(bus.MISO), 16'd0);
  endtask

  // Frame cut after nbits bits; no rx_valid may ever appear
  task automatic send_partial(input logic [9:0] w, input int nbits);
    bus.SS_n = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = w[9-i];
      tick();
      check("part_rx_valid", 16'(bus.rx_valid), 16'd0);
    end
    bus.SS_n = 1'b1;
    tick();
    check("abort_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("abort_miso", 16'(bus.MISO), 16'd0);
  endtask

  // Read-back after E10: e11 values shown at E11, delay idle edges, then new_b
  task automatic tx_readback(input logic [7:0] e11_b, input logic e11_v,
                             input logic [7:0] new_b, input int delay);
    logic b;
    bus.tx_data  = e11_b;
    bus.tx_valid = e11_v;
    tick();
    check("e11_miso", 16'(bus.MISO), 16'd0);
    check("e11_rx_valid", 16'(bus.rx_valid), 16'd0);
    for (int d = 0; d < delay; d++) begin
      bus.tx_valid = 1'b0;
      tick();
      check("wait_miso", 16'(bus.MISO), 16'd0);
    end
    for (int k = 7; k >= 0; k--) miso_exp_q.push_back(new_b[k]);
    bus.tx_data  = new_b;
    bus.tx_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      b = miso_exp_q.pop_front();
      check("miso_bit", 16'(bus.MISO), 16'(b));
      bus.tx_data = 8'hFF;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      check("miso_after", 16'(bus.MISO), 16'd0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    tick();
    tick();
    check("rst_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("rst_rx_data", 16'(bus.rx_data), 16'd0);
    check("rst_miso", 16'(bus.MISO), 16'd0);
    check("rst_rd_seen", 16'(dut.rd_addr_seen_q), 16'd0);
    rst_n = 1'b1;
    tick();

    // Write address and write data
    send_word(10'h005);
    end_frame();
    send_word(10'h1AA);
    check("wr_state", 16'(dut.state_q), 16'd2);
    check("wr_rd_seen", 16'(dut.rd_addr_seen_q), 16'd0);
    end_frame();

    // Read address then read data, byte A5 offered from E11
    send_word(10'h205);
    check("ra_rd_seen", 16'(dut.rd_addr_seen_q), 16'd1);
    end_frame();
    send_word(10'h3FF);
    check("rd_rd_seen", 16'(dut.rd_addr_seen_q), 16'd0);
    tx_readback(8'hA5, 1'b1, 8'hA5, 0);
    end_frame();

    // Stale tx_valid stays high; stale A5 at E11 must not be taken
    send_word(10'h2AB);
    end_frame();
    send_word(10'h300);
    tx_readback(8'hA5, 1'b1, 8'h3C, 0);
    end_frame();

    // Late tx_valid: three idle edges before the byte arrives
    bus.tx_valid = 1'b0;
    send_word(10'h212);
    end_frame();
    send_word(10'h3C0);
    tx_readback(8'h00, 1'b0, 8'h96, 3);
    end_frame();

    // Aborts after 6 bits and at E10, then a clean frame
    send_partial(10'h1F0, 6);
    send_word(10'h0F0);
    end_frame();
    send_partial(10'h2AA, 9);
    check("abort_rd_seen", 16'(dut.rd_addr_seen_q), 16'd0);
    send_word(10'h333);
    check("abort_next_state", 16'(dut.state_q), 16'd3);
    end_frame();

    // Reset during READ_DATA shift-out
    send_word(10'h2AA);
    end_frame();
    send_word(10'h355);
    bus.tx_data  = 8'hC3;
    bus.tx_valid = 1'b1;
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_miso", 16'(bus.MISO), 16'd0);
    check("mid_rst_rd_seen", 16'(dut.rd_addr_seen_q), 16'd0);
    check("mid_rst_state", 16'(dut.state_q), 16'd0);
    check("mid_rst_rx_data", 16'(bus.rx_data), 16'd0);
    rst_n    = 1'b1;
    bus.SS_n = 1'b1;
    tick();
    send_word(10'h3C3);
    check("post_rst_state", 16'(dut.state_q), 16'd3);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_miso", 16'(bus.MISO), 16'd0);
    end
    end_frame();
    bus.tx_valid = 1'b0;

    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
